access_code_tx: RTL and testbench
=================================

Name: access_code_tx

Overview:
- Transmit-side counterpart to the page-scan sync-word correlator.
- Serializes a Bluetooth access code onto a 1 Mbit/s bit stream, one bit per p_1us tick: 4-bit preamble, then 64-bit sync word (LSB first), then an optional 4-bit trailer.
- Sits between the page/inquiry control FSM (which supplies sync word and start pulse) and the GFSK modulator input.

Parameters:
- SYNC_W, 64, sync word width in bits; fixed at 64 for BT access codes.
- CNT_W, 7, width of the internal bit counter and of tx_bitcnt.

Ports:
- clk_6M  input  1  system clock, 6 MHz.
- rst  input  1  reset; one clock, reset is asynchronous and active-high.
- p_1us  input  1  one-cycle strobe every 1 us, synchronous to clk_6M.
- tx_start  input  1  one-cycle request; accepted only in IDLE.
- tx_abort  input  1  synchronous abort; highest priority after rst.
- sync_word  input  64  access code sync word; sampled on accept.
- trailer_req  input  1  sampled on accept; requests the trailer (macro-dependent).
- tx_bit  output  1  serial bit to the modulator.
- tx_valid  output  1  high while tx_bit carries a frame bit.
- tx_busy  output  1  high from the accept cycle until return to IDLE.
- tx_endp  output  1  one-cycle pulse when the frame completes normally.
- tx_bitcnt  output  7  index of the bit currently driven, 0-based across the whole frame.

Behaviour:
- Reset values: tx_bit=0, tx_valid=0, tx_busy=0, tx_endp=0, tx_bitcnt=0, state=IDLE. Reset clears all outputs immediately.
- States: IDLE, ARMED, PREAMBLE, SYNC, TRAILER.
- Accept: in IDLE, tx_start=1 does the following:
  - latch sync_word into a 64-bit shift register;
  - latch trailer_req, masked by the macro;
  - set tx_busy=1 on the next edge;
  - go to ARMED.
- tx_start in any other state is ignored; no queueing.
- ARMED -> PREAMBLE on the first p_1us strictly after the accept cycle. A p_1us in the same cycle as tx_start does not count.
- On that tick: tx_valid<=1, tx_bit<=first preamble bit, tx_bitcnt<=0.
- Preamble order on the wire is {s0, ~s0, s0, ~s0}, where s0 = sync_word[0]. The stream therefore alternates into the sync word.
- Each subsequent p_1us advances exactly one bit and increments tx_bitcnt. Outputs only change on p_1us cycles, except for abort and reset.
- After preamble bit 3: SYNC. Drives sync_word[0] .. sync_word[63]; tx_bitcnt runs 4..67.
- After sync bit 63:
  - trailer latched -> TRAILER. Order {~s63, s63, ~s63, s63}, tx_bitcnt 68..71.
  - otherwise -> end.
- End: on the p_1us that would advance past the last bit:
  - tx_valid<=0, tx_bit<=0, tx_busy<=0, tx_bitcnt<=0;
  - tx_endp<=1 for exactly one clk_6M cycle;
  - state<=IDLE.
- A tx_start in the cycle after tx_endp is accepted normally.
- Frame lengths: 68 tx_valid periods without trailer, 72 with trailer.
- tx_abort=1 in any non-IDLE state: next edge clears tx_valid, tx_bit, tx_busy and tx_bitcnt, and goes to IDLE. No tx_endp.
  - Abort and tx_start in the same cycle in IDLE: the start is ignored.
  - Abort in IDLE: no effect.
- Abort coincident with the final p_1us: abort wins; no tx_endp.
- sync_word and trailer_req changes after accept have no effect on the current frame.
- tx_bitcnt never exceeds 71; the counter does not wrap.

Optional Feature:
- Macro: ACCESS_CODE_TRAILER_EN.
- Defined: trailer_req is sampled on accept. When set, the 4-bit trailer is appended and the frame is 72 bits.
- Undefined: trailer_req is ignored (port retained, no logic); the frame is always 68 bits and the TRAILER state is never entered.

Test Plan:
- Basic frame, trailer_req=0, sync_word=64'h0000_0000_0000_0001, pulse tx_start.
  - Response: bits 1,0,1,0, then 1, then 63 zeros.
  - tx_valid high for exactly 68 p_1us periods; tx_bitcnt reaches 67.
  - Single tx_endp; tx_busy falls in the same cycle.
- Trailer frame, macro defined, trailer_req=1, sync_word=64'h8000_0000_0000_0000.
  - Response: 0,1,0,1, then 63 zeros, then 1, then trailer 0,1,0,1.
  - 72 periods; tx_bitcnt reaches 71.
  - Same stimulus with the macro undefined gives 68 bits and no trailer.
- Busy protection: second tx_start at bit 20, plus sync_word changed to all-ones at bit 10.
  - Response: frame unchanged; no second frame follows.
- Abort: tx_abort at tx_bitcnt=30.
  - Response: tx_valid=0 and tx_busy=0 on the next edge; no tx_endp.
  - A following tx_start produces a complete frame.
- Start timing: tx_start coincident with p_1us (p_1us every 6 clocks).
  - Response: first preamble bit appears on the next p_1us, 6 clocks later, not on the same tick.
- Async reset: rst asserted mid-sync at a non-edge time.
  - Response: all outputs 0 immediately.
  - After release the block sits in IDLE and a new tx_start works.

Source files
------------

// File: rtl/access_code_tx.sv
// access_code_tx: serializes a Bluetooth access code (preamble, sync word
// LSB first, optional trailer) onto a 1 Mbit/s stream, one bit per p_1us.
// Optional trailer support is compiled in with `define ACCESS_CODE_TRAILER_EN;
// without it trailer_req is ignored and every frame is 68 bits long.
module access_code_tx #(
  parameter int unsigned SYNC_W = 64,
  parameter int unsigned CNT_W  = 7
) (
  input  logic              clk_6M,
  input  logic              rst,
  input  logic              p_1us,
  input  logic              tx_start,
  input  logic              tx_abort,
  input  logic [SYNC_W-1:0] sync_word,
  input  logic              trailer_req,
  output logic              tx_bit,
  output logic              tx_valid,
  output logic              tx_busy,
  output logic              tx_endp,
  output logic [CNT_W-1:0]  tx_bitcnt
);

  localparam int unsigned PRE_LEN = 4;
  localparam int unsigned TRL_LEN = 4;

  // Counter values of the last bit in each frame section.
  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_LEN - 1);
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(PRE_LEN + SYNC_W - 1);
  localparam logic [CNT_W-1:0] TRL_LAST  = CNT_W'(PRE_LEN + SYNC_W + TRL_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARMED    = 3'd1,
    ST_PREAMBLE = 3'd2,
    ST_SYNC     = 3'd3,
    ST_TRAILER  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [SYNC_W-1:0]  shreg_q, shreg_d;
  logic               bit_q, bit_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               endp_q, endp_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_inc;
  logic               trl_en;

`ifdef ACCESS_CODE_TRAILER_EN
  logic trl_q, trl_d;
  assign trl_en = trl_q;
`else
  // Port kept for interface compatibility; no logic behind it.
  logic unused_trailer_req;
  assign unused_trailer_req = trailer_req;
  assign trl_en = 1'b0;
`endif

  assign cnt_inc = cnt_q + CNT_W'(1);

  // State and datapath registers; reset clears every output at once.
  always_ff @(posedge clk_6M or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      bit_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      endp_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef ACCESS_CODE_TRAILER_EN
      trl_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      endp_q  <= endp_d;
      cnt_q   <= cnt_d;
`ifdef ACCESS_CODE_TRAILER_EN
      trl_q   <= trl_d;
`endif
    end
  end

  // Next-state and output logic. Preamble and trailer are alternating
  // patterns, so each of their bits is simply the inverse of the previous one.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    endp_d  = 1'b0;
    cnt_d   = cnt_q;
`ifdef ACCESS_CODE_TRAILER_EN
    trl_d   = trl_q;
`endif

    if (tx_abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      bit_d   = 1'b0;
      valid_d = 1'b0;
      busy_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (tx_start && !tx_abort) begin
            shreg_d = sync_word;
            busy_d  = 1'b1;
            state_d = ST_ARMED;
`ifdef ACCESS_CODE_TRAILER_EN
            trl_d   = trailer_req;
`endif
          end
        end

        ST_ARMED: begin
          if (p_1us) begin
            state_d = ST_PREAMBLE;
            valid_d = 1'b1;
            bit_d   = shreg_q[0];
            cnt_d   = '0;
          end
        end

        ST_PREAMBLE: begin
          if (p_1us) begin
            cnt_d = cnt_inc;
            if (cnt_q == PRE_LAST) begin
              state_d = ST_SYNC;
              bit_d   = shreg_q[0];
              shreg_d = shreg_q >> 1;
            end else begin
              bit_d = ~bit_q;
            end
          end
        end

        ST_SYNC: begin
          if (p_1us) begin
            if (cnt_q == SYNC_LAST) begin
              if (trl_en) begin
                state_d = ST_TRAILER;
                bit_d   = ~bit_q;
                cnt_d   = cnt_inc;
              end else begin
                state_d = ST_IDLE;
                bit_d   = 1'b0;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                endp_d  = 1'b1;
                cnt_d   = '0;
              end
            end else begin
              bit_d   = shreg_q[0];
              shreg_d = shreg_q >> 1;
              cnt_d   = cnt_inc;
            end
          end
        end

        ST_TRAILER: begin
          if (p_1us) begin
            if (cnt_q == TRL_LAST) begin
              state_d = ST_IDLE;
              bit_d   = 1'b0;
              valid_d = 1'b0;
              busy_d  = 1'b0;
              endp_d  = 1'b1;
              cnt_d   = '0;
            end else begin
              bit_d = ~bit_q;
              cnt_d = cnt_inc;
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
          bit_d   = 1'b0;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign tx_bit    = bit_q;
  assign tx_valid  = valid_q;
  assign tx_busy   = busy_q;
  assign tx_endp   = endp_q;
  assign tx_bitcnt = cnt_q;

endmodule

// File: tb/tb_access_code_tx.sv
// Directed bench for access_code_tx: table of frames plus hand-written
// sequences for busy protection, abort, start timing and async reset.
module tb_access_code_tx;

  logic        clk_6M = 1'b0;
  logic        rst;
  logic        p_1us;
  logic        tx_start;
  logic        tx_abort;
  logic [63:0] sync_word;
  logic        trailer_req;
  logic        tx_bit;
  logic        tx_valid;
  logic        tx_busy;
  logic        tx_endp;
  logic [6:0]  tx_bitcnt;

  int   n_cmp = 0;
  int   n_err = 0;
  int   phase = 0;
  logic p_prev = 1'b0;

  always #5 clk_6M = ~clk_6M;

  access_code_tx dut (
    .clk_6M      (clk_6M),
    .rst         (rst),
    .p_1us       (p_1us),
    .tx_start    (tx_start),
    .tx_abort    (tx_abort),
    .sync_word   (sync_word),
    .trailer_req (trailer_req),
    .tx_bit      (tx_bit),
    .tx_valid    (tx_valid),
    .tx_busy     (tx_busy),
    .tx_endp     (tx_endp),
    .tx_bitcnt   (tx_bitcnt)
  );

  typedef struct {
    logic [63:0] sw;
    logic        trl;
    int          exp_len;
    logic [7:0]  exp_head;
    logic [3:0]  exp_tail;
  } vec_t;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge; p_prev is the strobe the DUT just saw.
  task automatic tick();
    @(negedge clk_6M);
    p_prev = p_1us;
    p_1us  = (phase == 5);
    phase  = (phase == 5) ? 0 : phase + 1;
  endtask

  function automatic void ref_frame(input logic [63:0] sw, input logic trl,
                                    output logic [71:0] b, output int n);
    logic t;
`ifdef ACCESS_CODE_TRAILER_EN
    t = trl;
`else
    t = trl & 1'b0;
`endif
    b = '0;
    for (int i = 0; i < 4; i++) b[i] = sw[0] ^ i[0];
    for (int i = 0; i < 64; i++) b[4 + i] = sw[i];
    if (t) for (int i = 0; i < 4; i++) b[68 + i] = ~sw[63] ^ i[0];
    n = t ? 72 : 68;
  endfunction

  // Start a frame and record it until tx_busy drops, with optional mid-frame
  // input changes, a second start, and an abort (optionally on a p_1us cycle).
  task automatic run_frame(input logic [63:0] sw, input logic trl, input int chg_at,
                           input int restart_at, input int abort_at, input bit abort_on_p,
                           output int len, output logic [71:0] bits, output int endps,
                           output int maxcnt, output int viol, output bit tmo);
    logic [8:0] prev;
    bit ab_prev;
    bit pend;
    len = 0; bits = '0; endps = 0; maxcnt = 0; viol = 0; tmo = 1'b1; pend = 1'b0;
    sync_word = sw; trailer_req = trl; tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    if (tx_busy !== 1'b1 || tx_valid !== 1'b0) viol++;
    prev = {tx_valid, tx_bit, tx_bitcnt};
    for (int g = 0; g < 1000; g++) begin
      tick();
      tx_start = 1'b0;
      ab_prev  = tx_abort;
      tx_abort = 1'b0;
      if (tx_endp === 1'b1) begin
        endps++;
        if (tx_busy !== 1'b0 || tx_valid !== 1'b0) viol++;
      end else if (!p_prev && !ab_prev && ({tx_valid, tx_bit, tx_bitcnt} !== prev)) begin
        viol++;
      end
      prev = {tx_valid, tx_bit, tx_bitcnt};
      if (p_prev && tx_valid === 1'b1) begin
        if (len < 72) bits[len] = tx_bit;
        if (tx_bitcnt !== 7'(len)) viol++;
        if (int'(tx_bitcnt) > maxcnt) maxcnt = int'(tx_bitcnt);
        if (len == chg_at) begin sync_word = '1; trailer_req = ~trl; end
        if (len == restart_at) tx_start = 1'b1;
        if (len == abort_at) pend = 1'b1;
        len++;
      end
      if (pend && (!abort_on_p || p_1us)) begin tx_abort = 1'b1; pend = 1'b0; end
      if (tx_busy === 1'b0) begin tmo = 1'b0; break; end
    end
  endtask

  vec_t        vecs[3];
  int          len, endps, maxcnt, viol, rlen, cnt;
  logic [71:0] bits, rbits;
  bit          tmo;

  initial begin
    rst = 1'b1; p_1us = 1'b0; tx_start = 1'b0; tx_abort = 1'b0;
    trailer_req = 1'b0; sync_word = '0;

    vecs[0] = '{64'h0000_0000_0000_0001, 1'b0, 68, 8'h15, 4'h0};
`ifdef ACCESS_CODE_TRAILER_EN
    vecs[1] = '{64'h8000_0000_0000_0000, 1'b1, 72, 8'h0A, 4'hA};
`else
    vecs[1] = '{64'h8000_0000_0000_0000, 1'b1, 68, 8'h0A, 4'h8};
`endif
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 68, 8'hEA, 4'hF};

    // Reset state
    tick(); tick();
    check("rst_bit",    72'(tx_bit),    72'd0);
    check("rst_valid",  72'(tx_valid),  72'd0);
    check("rst_busy",   72'(tx_busy),   72'd0);
    check("rst_endp",   72'(tx_endp),   72'd0);
    check("rst_bitcnt", 72'(tx_bitcnt), 72'd0);
    rst = 1'b0;
    repeat (3) tick();

    // Table-driven frames
    for (int v = 0; v < 3; v++) begin
      run_frame(vecs[v].sw, vecs[v].trl, -1, -1, -1, 1'b0, len, bits, endps, maxcnt, viol, tmo);
      ref_frame(vecs[v].sw, vecs[v].trl, rbits, rlen);
      check($sformatf("v%0d_timeout", v), 72'(tmo), 72'd0);
      check($sformatf("v%0d_len", v), 72'(len), 72'(vecs[v].exp_len));
      check($sformatf("v%0d_head", v), 72'(bits[7:0]), 72'(vecs[v].exp_head));
      if (len >= 4 && len <= 72)
        check($sformatf("v%0d_tail", v), 72'(bits[len-4 +: 4]), 72'(vecs[v].exp_tail));
      else
        check($sformatf("v%0d_tail_len", v), 72'(len), 72'(vecs[v].exp_len));
      check($sformatf("v%0d_bits", v), bits, rbits);
      check($sformatf("v%0d_maxcnt", v), 72'(maxcnt), 72'(rlen - 1));
      check($sformatf("v%0d_endps", v), 72'(endps), 72'd1);
      check($sformatf("v%0d_viol", v), 72'(viol), 72'd0);
      tick();
      check($sformatf("v%0d_endp_1cyc", v), 72'(tx_endp), 72'd0);
      repeat (3) tick();
    end

    // Busy protection: sync_word/trailer_req change at bit 10, restart at bit 20
    run_frame(64'h1, 1'b0, 10, 20, -1, 1'b0, len, bits, endps, maxcnt, viol, tmo);
    ref_frame(64'h1, 1'b0, rbits, rlen);
    check("busy_len", 72'(len), 72'd68);
    check("busy_bits", bits, rbits);
    check("busy_endps", 72'(endps), 72'd1);
    check("busy_viol", 72'(viol), 72'd0);
    cnt = 0;
    repeat (200) begin tick(); if (tx_valid !== 1'b0 || tx_busy !== 1'b0) cnt++; end
    check("busy_no_second", 72'(cnt), 72'd0);

    // Abort at bit 30
    run_frame(64'h0F0F_0F0F_0F0F_0F0F, 1'b0, -1, -1, 30, 1'b0, len, bits, endps, maxcnt, viol, tmo);
    check("abort_timeout", 72'(tmo), 72'd0);
    check("abort_len", 72'(len), 72'd31);
    check("abort_outs", 72'({tx_valid, tx_busy, tx_bit, tx_bitcnt}), 72'd0);
    check("abort_endps", 72'(endps), 72'd0);
    cnt = 0;
    repeat (60) begin tick(); if (tx_endp !== 1'b0 || tx_valid !== 1'b0) cnt++; end
    check("abort_quiet", 72'(cnt), 72'd0);
    run_frame(64'h0F0F_0F0F_0F0F_0F0F, 1'b0, -1, -1, -1, 1'b0, len, bits, endps, maxcnt, viol, tmo);
    ref_frame(64'h0F0F_0F0F_0F0F_0F0F, 1'b0, rbits, rlen);
    check("post_abort_bits", bits, rbits);
    check("post_abort_endps", 72'(endps), 72'd1);
    repeat (3) tick();

    // Abort coincident with the final p_1us
    run_frame(64'h1, 1'b0, -1, -1, 67, 1'b1, len, bits, endps, maxcnt, viol, tmo);
    check("abort_last_len", 72'(len), 72'd68);
    check("abort_last_endps", 72'(endps), 72'd0);
    cnt = 0;
    repeat (20) begin tick(); if (tx_endp !== 1'b0) cnt++; end
    check("abort_last_quiet", 72'(cnt), 72'd0);

    // Abort and start together in IDLE
    tx_start = 1'b1; tx_abort = 1'b1;
    tick();
    tx_start = 1'b0; tx_abort = 1'b0;
    check("idle_abort_start_busy", 72'(tx_busy), 72'd0);
    cnt = 0;
    repeat (20) begin tick(); if (tx_valid !== 1'b0) cnt++; end
    check("idle_abort_start_valid", 72'(cnt), 72'd0);

    // Start coincident with p_1us
    for (int i = 0; i < 10 && !p_1us; i++) tick();
    sync_word = 64'h1; trailer_req = 1'b0; tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    check("st_accept", 72'({tx_busy, tx_valid}), 72'b10);
    cnt = 1;
    while (tx_valid !== 1'b1 && cnt < 20) begin tick(); cnt++; end
    check("st_latency", 72'(cnt), 72'd7);
    check("st_first", 72'({tx_bit, tx_bitcnt}), 72'({1'b1, 7'd0}));
    tx_abort = 1'b1;
    tick();
    tx_abort = 1'b0;
    check("st_cleanup", 72'(tx_busy), 72'd0);
    repeat (3) tick();

    // Async reset mid-sync
    sync_word = 64'hDEAD_BEEF_0123_4567; tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    cnt = 0;
    while (!(tx_valid === 1'b1 && tx_bitcnt == 7'd40) && cnt < 2000) begin tick(); cnt++; end
    check("ar_reach_40", 72'(tx_bitcnt), 72'd40);
    #2 rst = 1'b1;
    #1;
    check("ar_outs", 72'({tx_bit, tx_valid, tx_busy, tx_endp, tx_bitcnt}), 72'd0);
    tick(); tick();
    rst = 1'b0;
    repeat (10) tick();
    check("ar_idle", 72'({tx_valid, tx_busy}), 72'd0);
    run_frame(64'h1, 1'b0, -1, -1, -1, 1'b0, len, bits, endps, maxcnt, viol, tmo);
    ref_frame(64'h1, 1'b0, rbits, rlen);
    check("ar_frame_bits", bits, rbits);
    check("ar_frame_endps", 72'(endps), 72'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
